// File: rtl/arb_pkg.sv
// Shared constants and helpers for the round-robin arbiter slice.
package arb_pkg;

   localparam int unsigned N_DEFAULT        = 4;
   localparam int unsigned HOLD_MAX_DEFAULT = 8;
   localparam int unsigned HOLD_CNT_W       = 8;

   // Width of a binary requester index; never narrower than one bit.
   function automatic int unsigned id_width(input int unsigned n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority one-hot picker: first set bit of (req & mask) at or after base, wrapping.
module rr_pick
   import arb_pkg::*;
#(
   parameter int unsigned N   = N_DEFAULT,
   parameter int unsigned IDW = id_width(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] base,
   input  logic [N-1:0]   mask,
   output logic [N-1:0]   winner
);

   logic [N-1:0] cand;
   logic [N-1:0] rot_n;
   logic [N-1:0] first;

   // Rotate so base sits at bit 0, isolate the lowest set bit, rotate back.
   always_comb begin
      cand   = req & mask;
      rot_n  = N'({cand, cand} >> base);
      first  = rot_n & (~rot_n + N'(1));
      winner = N'({first, first} << base >> N);
   end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter with registered one-hot grant.
// Optional grant hold/lock is compiled in with macro ARB_HOLD_EN.
module rr_arbiter_n
   import arb_pkg::*;
#(
   parameter  int unsigned N        = N_DEFAULT,
   parameter  int unsigned HOLD_MAX = HOLD_MAX_DEFAULT,
   localparam int unsigned IDW      = id_width(N)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   grant,
   output logic           grant_valid,
   output logic [IDW-1:0] grant_id
);

   if (N < 2 || N > 16) begin : g_bad_n
      $error("rr_arbiter_n: N must be in 2..16");
   end
   if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
      $error("rr_arbiter_n: HOLD_MAX must be in 1..255");
   end

   logic [IDW-1:0] last_id;
   logic [IDW-1:0] last_id_nxt;
   logic [IDW-1:0] base;
   logic [N-1:0]   pick_mask;
   logic [N-1:0]   win;
   logic [N-1:0]   grant_nxt;
   logic           valid_nxt;
   logic [IDW-1:0] id_nxt;

`ifdef ARB_HOLD_EN
   localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_MAX - 1);
   logic [HOLD_CNT_W-1:0] hold_cnt;
   logic [HOLD_CNT_W-1:0] hold_cnt_nxt;
   logic                  owner_req;
   logic                  other_req;
   logic                  keep;
`endif

   // Search starts just after the previous winner.
   always_comb begin
      base = (last_id == IDW'(N - 1)) ? '0 : last_id + IDW'(1);
   end

   // When re-arbitrating away from a current owner, the owner is never a candidate.
   always_comb begin
      pick_mask = '1;
`ifdef ARB_HOLD_EN
      if (grant_valid) pick_mask = ~grant;
`endif
   end

   rr_pick #(
      .N   (N),
      .IDW (IDW)
   ) u_pick (
      .req    (req),
      .base   (base),
      .mask   (pick_mask),
      .winner (win)
   );

   // Next grant, index and priority pointer.
   always_comb begin
      grant_nxt = win;
`ifdef ARB_HOLD_EN
      hold_cnt_nxt = '0;
      owner_req    = |(req & grant);
      other_req    = |(req & ~grant);
      keep         = owner_req && ((hold_cnt < HOLD_LAST) || !other_req);
      if (keep) begin
         grant_nxt    = grant;
         hold_cnt_nxt = (hold_cnt < HOLD_LAST) ? hold_cnt + HOLD_CNT_W'(1) : hold_cnt;
      end
`endif
      valid_nxt = |grant_nxt;
      id_nxt    = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (grant_nxt[i]) id_nxt = IDW'(i);
      end
      last_id_nxt = valid_nxt ? id_nxt : last_id;
   end

   // State register; reset overrides any request or held grant.
   always_ff @(posedge clk) begin
      if (reset) begin
         grant       <= '0;
         grant_valid <= 1'b0;
         grant_id    <= '0;
         last_id     <= IDW'(N - 1);
`ifdef ARB_HOLD_EN
         hold_cnt    <= '0;
`endif
      end else begin
         grant       <= grant_nxt;
         grant_valid <= valid_nxt;
         grant_id    <= id_nxt;
         last_id     <= last_id_nxt;
`ifdef ARB_HOLD_EN
         hold_cnt    <= hold_cnt_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Scoreboard bench for rr_arbiter_n (N=4, HOLD_MAX=4), with or without ARB_HOLD_EN.
module tb_rr_arbiter_n;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic [3:0] grant;
   logic       grant_valid;
   logic [1:0] grant_id;

   typedef struct {
      logic [3:0] grant;
      logic       valid;
      logic [1:0] id;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   rr_arbiter_n #(
      .N        (4),
      .HOLD_MAX (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs; expectation is queued once the sampling edge has passed.
   task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] eg,
                       input logic [1:0] eid, input string nm);
      exp_t e;
      reset = r;
      req   = rq;
      @(posedge clk);
      e.grant = eg;
      e.valid = |eg;
      e.id    = eid;
      e.name  = nm;
      sb.push_back(e);
      #1;
   endtask

   // Monitor: compare registered outputs half a cycle after each edge.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         if (grant !== e.grant || grant_valid !== e.valid || grant_id !== e.id) begin
            errors++;
            $display("FAIL %s: got grant=%b valid=%b id=%0d, want grant=%b valid=%b id=%0d",
                     e.name, grant, grant_valid, grant_id, e.grant, e.valid, e.id);
         end
      end
   end

   initial begin
      // Reset wins over requests
      step(1'b1, 4'b1111, 4'b0000, 2'd0, "reset0");
      step(1'b1, 4'b1111, 4'b0000, 2'd0, "reset1");

      // All requesting from reset
`ifdef ARB_HOLD_EN
      for (int i = 0; i < 4; i++) step(1'b0, 4'b1111, 4'b0001, 2'd0, "hold_r0");
      for (int i = 0; i < 4; i++) step(1'b0, 4'b1111, 4'b0010, 2'd1, "hold_r1");
      step(1'b0, 4'b1111, 4'b0100, 2'd2, "hold_r2");
`else
      step(1'b0, 4'b1111, 4'b0001, 2'd0, "rot0");
      step(1'b0, 4'b1111, 4'b0010, 2'd1, "rot1");
      step(1'b0, 4'b1111, 4'b0100, 2'd2, "rot2");
      step(1'b0, 4'b1111, 4'b1000, 2'd3, "rot3");
      step(1'b0, 4'b1111, 4'b0001, 2'd0, "rot_wrap");
`endif

      // Single constant requester
      step(1'b1, 4'b0000, 4'b0000, 2'd0, "reset2");
      for (int i = 0; i < 3; i++) step(1'b0, 4'b0100, 4'b0100, 2'd2, "const2");

      // Reset pulse while granted, then all request
      step(1'b1, 4'b0100, 4'b0000, 2'd0, "reset_mid");
      step(1'b0, 4'b1111, 4'b0001, 2'd0, "post_reset");

      // Idle, then set last_id=1, idle, then 1010
      step(1'b0, 4'b0000, 4'b0000, 2'd0, "idle0");
      step(1'b0, 4'b0010, 4'b0010, 2'd1, "set_last1");
      step(1'b0, 4'b0000, 4'b0000, 2'd0, "idle1");
      step(1'b0, 4'b1010, 4'b1000, 2'd3, "pick_1010");
`ifdef ARB_HOLD_EN
      step(1'b0, 4'b1010, 4'b1000, 2'd3, "keep_1010");
`else
      step(1'b0, 4'b1010, 4'b0010, 2'd1, "next_1010");
`endif

      // Owner drops its request
      step(1'b1, 4'b0000, 4'b0000, 2'd0, "reset3");
      step(1'b0, 4'b0011, 4'b0001, 2'd0, "drop_a");
`ifdef ARB_HOLD_EN
      step(1'b0, 4'b0011, 4'b0001, 2'd0, "drop_b");
`else
      step(1'b0, 4'b0011, 4'b0010, 2'd1, "drop_b");
`endif
      step(1'b0, 4'b0010, 4'b0010, 2'd1, "drop_c");

      // Simultaneous rise from idle after last_id=1
      step(1'b0, 4'b0000, 4'b0000, 2'd0, "idle2");
      step(1'b0, 4'b1101, 4'b0100, 2'd2, "simul");

      // Wrap from index 3 to 0
      step(1'b0, 4'b1000, 4'b1000, 2'd3, "last3");
      step(1'b0, 4'b0000, 4'b0000, 2'd0, "idle3");
      step(1'b0, 4'b1001, 4'b0001, 2'd0, "wrap0");
      step(1'b0, 4'b0000, 4'b0000, 2'd0, "idle4");

      for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
